// File: rtl/ternary_vector_mac.sv
`default_nettype none
// ternary_vector_mac: ternary-weight vector MAC, 2-stage pipeline, DOT/MUL/POOL modes.
// Build macro TERNARY_MAC_SATURATE_EN: clamp DOT/POOL-sum accumulation instead of wrapping.
module ternary_vector_mac #(
    parameter int LANES = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             exec_hints,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [2*LANES-1:0]      weights,
    input  logic [2*LANES-1:0]      trits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] result,
    output logic [CNT_W-1:0]        skip_count,
    output logic [CNT_W-1:0]        active_cycles,
    output logic                    overflow
);
    localparam int PC_W = $clog2(LANES + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [7:0]              op_mode_q;
    logic                    skip_en_q;
    logic [1:0]              pool_op_q;
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] result_q;

    logic                    s1_valid_q;
    logic signed [ACC_W-1:0] s1_sum_q;
    logic                    s1_last_q;
    logic                    s1_first_q;
    logic [PC_W-1:0]         s1_zero_q;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    overflow_q, overflow_d;
    logic                    done_q;
    logic [CNT_W-1:0]        skip_q, skip_d;
    logic [CNT_W-1:0]        active_q;

    logic                    w_accept;
    logic [LANES-1:0]        w_lane_nz;
    logic [LANES-1:0]        w_lane_neg;
    logic signed [ACC_W-1:0] w_beat_sum;
    logic [PC_W-1:0]         w_zero_cnt;
    logic signed [ACC_W-1:0] w_add_sum;
    logic signed [ACC_W-1:0] w_add_res;
    logic                    w_add_ovf;
    logic                    w_is_dot;
    logic                    w_is_mul;
    logic                    w_is_pool;
    logic                    w_unused_hints;

    assign in_ready       = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign w_accept       = in_valid && in_ready;
    assign w_unused_hints = ^{exec_hints[31], exec_hints[28:18], exec_hints[16:8]};

    // Codes 01 and 10 are the only non-zero trits; the product is negative when exactly one is 10.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_lane_nz[i]  = (weights[2*i] ^ weights[2*i+1]) && (trits[2*i] ^ trits[2*i+1]);
        assign w_lane_neg[i] = weights[2*i+1] ^ trits[2*i+1];
    end

    always_comb begin
        w_beat_sum = '0;
        w_zero_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_lane_nz[i]) begin
                w_beat_sum = w_lane_neg[i] ? (w_beat_sum - ACC_ONE) : (w_beat_sum + ACC_ONE);
            end else begin
                w_zero_cnt = w_zero_cnt + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_last_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_zero_q  <= '0;
            active_q   <= '0;
        end else begin
            s1_valid_q <= w_accept;
            if (w_accept) begin
                s1_sum_q   <= w_beat_sum;
                s1_last_q  <= in_last;
                s1_first_q <= (state_q == S_IDLE);
                s1_zero_q  <= w_zero_cnt;
                active_q   <= active_q + CNT_W'(1);
            end
        end
    end

    assign w_is_dot  = (op_mode_q == 8'h01) || (op_mode_q == 8'h04) || (op_mode_q == 8'h06) ||
                       (op_mode_q == 8'h07) || (op_mode_q == 8'h08) || (op_mode_q == 8'h09);
    assign w_is_mul  = (op_mode_q == 8'h03);
    assign w_is_pool = (op_mode_q == 8'h05);

    always_comb begin
        w_add_sum = acc_q + s1_sum_q;
        w_add_ovf = (acc_q[ACC_W-1] == s1_sum_q[ACC_W-1]) && (w_add_sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef TERNARY_MAC_SATURATE_EN
        w_add_res = w_add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_add_sum;
`else
        w_add_res = w_add_sum;
`endif
        acc_d      = acc_q;
        overflow_d = overflow_q;
        skip_d     = skip_q;
        if (s1_valid_q) begin
            if (skip_en_q) begin
                skip_d = skip_q + CNT_W'(s1_zero_q);
            end
            // The first beat loads the accumulator directly, so it can never overflow.
            if (w_is_dot || (w_is_pool && pool_op_q == 2'b10)) begin
                if (s1_first_q) begin
                    acc_d = s1_sum_q;
                end else begin
                    acc_d      = w_add_res;
                    overflow_d = overflow_q | w_add_ovf;
                end
            end else if (w_is_mul) begin
                acc_d = s1_sum_q;
            end else if (w_is_pool && pool_op_q == 2'b00) begin
                acc_d = (s1_first_q || (s1_sum_q > acc_q)) ? s1_sum_q : acc_q;
            end else if (w_is_pool && pool_op_q == 2'b01) begin
                acc_d = (s1_first_q || (s1_sum_q < acc_q)) ? s1_sum_q : acc_q;
            end else begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            overflow_q <= 1'b0;
            skip_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
            skip_q     <= skip_d;
            done_q     <= s1_valid_q && s1_last_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_mode_q   <= '0;
            skip_en_q   <= 1'b0;
            pool_op_q   <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        op_mode_q <= exec_hints[7:0];
                        skip_en_q <= exec_hints[17];
                        pool_op_q <= exec_hints[30:29];
                        state_q   <= in_last ? S_FLUSH : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept && in_last) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (done_q) begin
                        result_q    <= acc_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign skip_count    = skip_q;
    assign active_cycles = active_q;
    assign overflow      = overflow_q;

endmodule
`default_nettype wire
